imem_loader: RTL

- Writer-side counterpart to the instruction-fetch reader. It accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words.
- Each packed word is written through the instruction-memory write port.
- The core is held in reset (cpu_hold) until a complete program image has been loaded.
- Sits between a host byte source (UART or JTAG bridge) and the instruction memory, beside the single-cycle core.

---
 rtl/imem_loader_pkg.sv | 34 +++
 rtl/imem_loader_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// image framing constants and header decoding.
package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_W        = 8 * HDR_BYTES;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } loader_state_t;

  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA);
  endfunction

  // An empty image is complete immediately; an oversize one can never fit.
  function automatic loader_state_t header_next(input logic [COUNT_W-1:0] count,
                                                input logic [COUNT_W-1:0] depth);
    if (count == '0)
      return S_DONE;
    else if (count > depth)
      return S_ERR;
    else
      return S_DATA;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: each shifted-in byte lands in the
// lane selected by the running byte index.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [31:0]           word;

  // word_next already contains the incoming byte so the word can be captured
  // on the same edge that accepts the final byte.
  always_comb begin
    word_next = word;
    word_next[8*byte_idx +: 8] = byte_in;
  end

  assign word_full = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (shift_in) begin
      word     <= word_next;
      byte_idx <= byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the
// core in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int width       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              start,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [width-1:0]  imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [COUNT_W-1:0] DEPTH_COUNT = COUNT_W'(DEPTH_WORDS);

  loader_state_t      state;
  logic [COUNT_W-1:0] word_count;
  logic [COUNT_W-1:0] hdr_count;
  logic [ADDR_W-1:0]  word_addr;
  logic               rx_fire;
  logic               last_word;
  logic [31:0]        word_next;
  logic               word_full;

  // load_req blocks the handshake so a byte offered during an abort is not lost.
  assign rx_ready  = accepts_bytes(state) && !load_req;
  assign rx_fire   = rx_valid && rx_ready;
  assign hdr_count = {rx_data, word_count[7:0]};
  assign last_word = (COUNT_W'(words_loaded) + COUNT_W'(1)) == word_count;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (start),
    .clear     (load_req),
    .shift_in  (rx_fire && (state == S_DATA)),
    .byte_in   (rx_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      state        <= S_HDR0;
      word_count   <= '0;
      word_addr    <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else if (load_req) begin
      state        <= S_HDR0;
      word_count   <= '0;
      word_addr    <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      case (state)
        S_HDR0: begin
          if (rx_fire) begin
            word_count[7:0] <= rx_data;
            state           <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (rx_fire) begin
            word_count[15:8] <= rx_data;
            state            <= header_next(hdr_count, DEPTH_COUNT);
            if (hdr_count == '0) begin
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else if (hdr_count > DEPTH_COUNT) begin
              load_err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (rx_fire && word_full) begin
            state      <= S_WRITE;
            imem_we    <= 1'b1;
            imem_wdata <= width'(word_next);
            imem_addr  <= word_addr;
          end
        end
        S_WRITE: begin
          imem_we      <= 1'b0;
          word_addr    <= word_addr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
          if (last_word) begin
            state     <= S_DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        S_DONE, S_ERR: begin
          state <= state;
        end
        default: begin
          state <= S_HDR0;
        end
      endcase
    end
  end

endmodule
